grayscale_host_mem: RTL

GRAYSCALE_HOST_MEM -- requirements
Module: grayscale_host_mem

---
 rtl/grayscale_host_mem.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/grayscale_host_mem.sv
// Host memory model: queued read/write channels over a 512-bit line store with fixed response latency.
// Optional statistics counters are built when GRAYSCALE_HOST_MEM_STATS_EN is defined.
module grayscale_host_mem #(
   parameter int ADDR_W     = 10,
   parameter int QDEPTH     = 16,
   parameter int ALMFULL_TH = 8,
   parameter int LATENCY    = 4,
   parameter int RD_GAP     = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         c0_req_valid,
   input  logic [41:0]  c0_req_addr,
   input  logic [15:0]  c0_req_mdata,
   input  logic         c1_req_valid,
   input  logic [41:0]  c1_req_addr,
   input  logic [15:0]  c1_req_mdata,
   input  logic [511:0] c1_req_data,
   output logic         c0_almfull,
   output logic         c1_almfull,
   output logic         c0_rsp_valid,
   output logic [15:0]  c0_rsp_mdata,
   output logic [511:0] c0_rsp_data,
   output logic         c1_rsp_valid,
   output logic [15:0]  c1_rsp_mdata,
   output logic         err_overflow,
   output logic [31:0]  rd_count,
   output logic [31:0]  wr_count
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int GAP_W = $clog2(RD_GAP + 1) + 1;
   localparam logic [CNT_W-1:0] QFULL   = CNT_W'(QDEPTH);
   localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(ALMFULL_TH);
   localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(RD_GAP);

   logic [511:0]      store [2**ADDR_W];

   logic [ADDR_W-1:0] rq_addr  [QDEPTH];
   logic [15:0]       rq_mdata [QDEPTH];
   logic [PTR_W-1:0]  rq_wp, rq_rp;
   logic [CNT_W-1:0]  rq_cnt;

   logic [ADDR_W-1:0] wq_addr  [QDEPTH];
   logic [15:0]       wq_mdata [QDEPTH];
   logic [511:0]      wq_data  [QDEPTH];
   logic [PTR_W-1:0]  wq_wp, wq_rp;
   logic [CNT_W-1:0]  wq_cnt;

   logic [GAP_W-1:0]  gap_cnt;

   logic              rd_vld_p   [LATENCY];
   logic [15:0]       rd_mdata_p [LATENCY];
   logic [511:0]      rd_data_p  [LATENCY];
   logic              wr_vld_p   [LATENCY];
   logic [15:0]       wr_mdata_p [LATENCY];

   logic              rq_push, rq_drop, rq_pop;
   logic              wq_push, wq_drop, wq_pop;
   logic [ADDR_W-1:0] rd_idx_p0, wr_idx_p0;
   logic [511:0]      rd_word_p0;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{c0_req_addr[41:ADDR_W], c1_req_addr[41:ADDR_W]};

   assign rq_push = c0_req_valid && (rq_cnt < QFULL);
   assign rq_drop = c0_req_valid && !(rq_cnt < QFULL);
   assign wq_push = c1_req_valid && (wq_cnt < QFULL);
   assign wq_drop = c1_req_valid && !(wq_cnt < QFULL);

   assign rq_pop  = (rq_cnt != '0) && (gap_cnt >= GAP_MIN);
   assign wq_pop  = (wq_cnt != '0);

   // Stage p0: FIFO heads; a write retiring this cycle to the same line wins over the store
   assign rd_idx_p0  = rq_addr[rq_rp];
   assign wr_idx_p0  = wq_addr[wq_rp];
   assign rd_word_p0 = (wq_pop && (wr_idx_p0 == rd_idx_p0)) ? wq_data[wq_rp] : store[rd_idx_p0];

   always_ff @(posedge clk) begin
      if (reset) begin
         rq_wp        <= '0;
         rq_rp        <= '0;
         rq_cnt       <= '0;
         wq_wp        <= '0;
         wq_rp        <= '0;
         wq_cnt       <= '0;
         gap_cnt      <= GAP_MIN;
         c0_almfull   <= 1'b0;
         c1_almfull   <= 1'b0;
         err_overflow <= 1'b0;
         for (int i = 0; i < LATENCY; i++) begin
            rd_vld_p[i] <= 1'b0;
            wr_vld_p[i] <= 1'b0;
         end
      end else begin
         if (rq_push) rq_wp <= rq_wp + PTR_W'(1);
         if (rq_pop)  rq_rp <= rq_rp + PTR_W'(1);
         if (wq_push) wq_wp <= wq_wp + PTR_W'(1);
         if (wq_pop)  wq_rp <= wq_rp + PTR_W'(1);
         rq_cnt <= rq_cnt + CNT_W'(rq_push) - CNT_W'(rq_pop);
         wq_cnt <= wq_cnt + CNT_W'(wq_push) - CNT_W'(wq_pop);

         if (rq_pop)                 gap_cnt <= GAP_W'(1);
         else if (gap_cnt < GAP_MIN) gap_cnt <= gap_cnt + GAP_W'(1);

         c0_almfull   <= (rq_cnt >= AF_TH);
         c1_almfull   <= (wq_cnt >= AF_TH);
         err_overflow <= err_overflow | rq_drop | wq_drop;

         rd_vld_p[0] <= rq_pop;
         wr_vld_p[0] <= wq_pop;
         for (int i = 1; i < LATENCY; i++) begin
            rd_vld_p[i] <= rd_vld_p[i-1];
            wr_vld_p[i] <= wr_vld_p[i-1];
         end
      end
   end

   // Stage p1..pLATENCY: payload storage and delay line, no reset needed
   always_ff @(posedge clk) begin
      if (rq_push) begin
         rq_addr[rq_wp]  <= c0_req_addr[ADDR_W-1:0];
         rq_mdata[rq_wp] <= c0_req_mdata;
      end
      if (wq_push) begin
         wq_addr[wq_wp]  <= c1_req_addr[ADDR_W-1:0];
         wq_mdata[wq_wp] <= c1_req_mdata;
         wq_data[wq_wp]  <= c1_req_data;
      end
      if (wq_pop) store[wr_idx_p0] <= wq_data[wq_rp];

      rd_mdata_p[0] <= rq_mdata[rq_rp];
      rd_data_p[0]  <= rd_word_p0;
      wr_mdata_p[0] <= wq_mdata[wq_rp];
      for (int i = 1; i < LATENCY; i++) begin
         rd_mdata_p[i] <= rd_mdata_p[i-1];
         rd_data_p[i]  <= rd_data_p[i-1];
         wr_mdata_p[i] <= wr_mdata_p[i-1];
      end
   end

   // Payload is masked by the registered valid so idle outputs read as zero
   assign c0_rsp_valid = rd_vld_p[LATENCY-1];
   assign c0_rsp_mdata = rd_vld_p[LATENCY-1] ? rd_mdata_p[LATENCY-1] : 16'h0;
   assign c0_rsp_data  = rd_vld_p[LATENCY-1] ? rd_data_p[LATENCY-1]  : 512'h0;
   assign c1_rsp_valid = wr_vld_p[LATENCY-1];
   assign c1_rsp_mdata = wr_vld_p[LATENCY-1] ? wr_mdata_p[LATENCY-1] : 16'h0;

`ifdef GRAYSCALE_HOST_MEM_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (c0_rsp_valid) rd_cnt_q <= rd_cnt_q + 32'd1;
         if (c1_rsp_valid) wr_cnt_q <= wr_cnt_q + 32'd1;
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`else
   assign rd_count = 32'h0;
   assign wr_count = 32'h0;
`endif

endmodule
